// File: rtl/dwt_pkg.sv
// Shared types and defaults for the sym4 DWT frame sequencing stages.
package dwt_pkg;

    localparam int unsigned DATA_WIDTH  = 16;
    localparam int unsigned LANES       = 16;
    localparam int unsigned PIPE_LAT    = 6;
    localparam int unsigned FLUSH_BEATS = 1;
    localparam int unsigned CREDITS     = 8;
    localparam int unsigned LEN_W       = 10;

    typedef struct packed {
        logic v;
        logic sof;
        logic eof;
    } tag_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/dwt_tag_pipe.sv
// Fixed-latency shift register of beat tags, mirroring a datapath pipeline.
module dwt_tag_pipe
    import dwt_pkg::*;
#(
    parameter int unsigned DEPTH = dwt_pkg::PIPE_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t in_tag,
    output tag_t tail,
    output logic empty
);

    tag_t stages [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= in_tag;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    // empty looks one edge ahead: nothing valid remains once the tail shifts out
    always_comb begin
        empty = !in_tag.v;
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            if (stages[i].v) empty = 1'b0;
        end
        tail = stages[DEPTH-1];
    end

endmodule

// File: rtl/dwt_l1_frame_sequencer.sv
// Frames 16-sample beats into decompose_L1, appends flush beats, and tags outputs.
module dwt_l1_frame_sequencer
    import dwt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = dwt_pkg::DATA_WIDTH,
    parameter int unsigned LANES       = dwt_pkg::LANES,
    parameter int unsigned PIPE_LAT    = dwt_pkg::PIPE_LAT,
    parameter int unsigned FLUSH_BEATS = dwt_pkg::FLUSH_BEATS,
    parameter int unsigned CREDITS     = dwt_pkg::CREDITS,
    parameter int unsigned LEN_W       = dwt_pkg::LEN_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [LEN_W-1:0]            frame_len,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [LANES*DATA_WIDTH-1:0] s_data,
    output logic                        dec_din_valid,
    output logic [LANES*DATA_WIDTH-1:0] dec_din,
    input  logic                        dec_dout_valid,
    output logic                        m_valid,
    output logic                        m_sof,
    output logic                        m_eof,
    input  logic                        credit_ret,
    output logic                        frame_done,
    output logic                        busy,
    output logic                        err_sync,
    output logic                        err_cfg
);

    localparam int unsigned CW = $clog2(CREDITS + 1);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt;
    logic [CW-1:0]    credits;
    logic             dec_sof;
    logic             dec_eof;
    logic             issue_data;
    logic             issue_flush;
    logic             issue;
    logic             pipe_empty;
    tag_t             in_tag;
    tag_t             tail;

    always_comb begin
        s_ready     = (state == S_RUN) && (credits != '0);
        issue_data  = s_ready && s_valid;
        issue_flush = (state == S_FLUSH) && (credits != '0);
        issue       = issue_data || issue_flush;
        busy        = (state != S_IDLE);
        in_tag.v    = dec_din_valid;
        in_tag.sof  = dec_sof;
        in_tag.eof  = dec_eof;
        m_valid     = tail.v;
        m_sof       = tail.v && tail.sof;
        m_eof       = tail.v && tail.eof;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            len_q         <= '0;
            beat_cnt      <= '0;
            credits       <= CW'(CREDITS);
            dec_din_valid <= 1'b0;
            dec_din       <= '0;
            dec_sof       <= 1'b0;
            dec_eof       <= 1'b0;
            frame_done    <= 1'b0;
            err_cfg       <= 1'b0;
        end else begin
            dec_din_valid <= issue;
            dec_sof       <= issue_data && (beat_cnt == '0);
            dec_eof       <= issue_flush && (beat_cnt == LEN_W'(FLUSH_BEATS - 1));
            frame_done    <= 1'b0;

            // Simultaneous issue and return cancel; an unmatched return at full scale is an overflow
            if (issue && !credit_ret) begin
                credits <= credits - 1'b1;
            end else if (credit_ret && !issue) begin
                if (credits == CW'(CREDITS)) err_cfg <= 1'b1;
                else                         credits <= credits + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (enable) begin
                        if (frame_len != '0) begin
                            len_q    <= frame_len;
                            beat_cnt <= '0;
                            state    <= S_RUN;
                        end else begin
                            err_cfg <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (issue_data) begin
                        dec_din <= s_data;
                        if (beat_cnt == len_q - 1'b1) begin
                            beat_cnt <= '0;
                            state    <= S_FLUSH;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (issue_flush) begin
                        dec_din <= '0;
                        if (beat_cnt == LEN_W'(FLUSH_BEATS - 1)) begin
                            beat_cnt <= '0;
                            state    <= S_DRAIN;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty) begin
                        frame_done <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sync <= 1'b0;
        end else if (dec_dout_valid != tail.v) begin
            err_sync <= 1'b1;
        end
    end

    dwt_tag_pipe #(
        .DEPTH (PIPE_LAT)
    ) u_tag_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_tag (in_tag),
        .tail   (tail),
        .empty  (pipe_empty)
    );

endmodule
